// File: rtl/attention_av_stream_bridge_if.sv
// Signal bundle between the A×V stream bridge and its neighbours: input word stream,
// engine operand/result buses and output word stream.
interface attention_av_stream_bridge_if #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8
);
    // Handshake: a word transfers on a rising clk edge where valid && ready; the source
    // holds data (and last) stable while valid && !ready.
    logic                         s_valid;
    logic                         s_ready;
    logic [DATA_WIDTH-1:0]        s_data;

    logic                         eng_start;
    logic [DATA_WIDTH*L*N*L-1:0]  eng_A;
    logic [DATA_WIDTH*L*N*E-1:0]  eng_V;
    logic [L-1:0][3:0]            eng_prec;
    logic                         eng_done;
    logic [DATA_WIDTH*L*N*E-1:0]  eng_Z;

    logic                         m_valid;
    logic                         m_ready;
    logic [DATA_WIDTH-1:0]        m_data;
    logic                         m_last;

    modport slave (
        input  s_valid, s_data, eng_done, eng_Z, m_ready,
        output s_ready, eng_start, eng_A, eng_V, eng_prec, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, eng_done, eng_Z, m_ready,
        input  s_ready, eng_start, eng_A, eng_V, eng_prec, m_valid, m_data, m_last
    );
endinterface

// File: rtl/attention_av_stream_bridge.sv
// Loads A, V and precision words from a stream, runs one engine job, streams Z back out.
// Optional watchdog on the engine wait enabled by defining ATTN_BRIDGE_WDOG_EN.
module attention_av_stream_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    attention_av_stream_bridge_if.slave    bus,
    output logic                           busy,
    output logic                           err,
    output logic [1:0]                     o_dbg_state
);
    localparam int NA = L * N * L;
    localparam int NV = L * N * E;
    localparam int W  = NA + NV + L;
    localparam int CW = $clog2(W);
    localparam int RW = (NV > 1) ? $clog2(NV) : 1;
    localparam logic [CW-1:0] W_LAST = CW'(W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(NV - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [CW-1:0]               r_cnt, w_cnt_nxt;
    logic [RW-1:0]               r_rd, w_rd_nxt;
    logic                        r_eng_start, r_m_valid, r_m_last, r_busy;
    logic [DATA_WIDTH-1:0]       r_m_data, w_zword;
    logic [DATA_WIDTH*NA-1:0]    r_eng_A;
    logic [DATA_WIDTH*NV-1:0]    r_eng_V, r_zbuf, w_zsrc;
    logic [L-1:0][3:0]           r_eng_prec;
    logic                        w_s_hs, w_m_hs, w_cap, w_timeout;

    assign w_s_hs = (r_state == S_LOAD) && bus.s_valid;
    assign w_m_hs = (r_state == S_DRAIN) && bus.m_ready;
    assign w_cap  = (r_state == S_WAIT) && bus.eng_done;
    // On the capture cycle the first output word comes straight from the engine bus.
    assign w_zsrc = w_cap ? bus.eng_Z : r_zbuf;

`ifdef ATTN_BRIDGE_WDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_wdog;
    logic          r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_wdog <= '0;
        else if (r_state == S_START) r_wdog <= TW'(1);
        else if (r_state == S_WAIT)  r_wdog <= r_wdog + 1'b1;
        else                         r_wdog <= '0;
    end

    assign w_timeout = (r_state == S_WAIT) && !bus.eng_done && (r_wdog == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_nxt    = r_rd;
        case (r_state)
            S_LOAD: begin
                if (w_s_hs) begin
                    if (r_cnt == W_LAST) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_cap) begin
                    w_state_nxt = S_DRAIN;
                    w_rd_nxt    = '0;
                end else if (w_timeout) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (w_m_hs) begin
                    if (r_rd == R_LAST) begin
                        w_state_nxt = S_LOAD;
                        w_rd_nxt    = '0;
                    end else begin
                        w_rd_nxt = r_rd + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        w_zword = '0;
        for (int i = 0; i < NV; i++)
            if (w_rd_nxt == RW'(i)) w_zword = w_zsrc[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_eng_start <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_data    <= '0;
            r_busy      <= 1'b0;
            r_eng_A     <= '0;
            r_eng_V     <= '0;
            r_eng_prec  <= '0;
            r_zbuf      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rd        <= w_rd_nxt;
            r_eng_start <= (w_state_nxt == S_START);
            r_m_valid   <= (w_state_nxt == S_DRAIN);
            r_m_last    <= (w_state_nxt == S_DRAIN) && (w_rd_nxt == R_LAST);
            r_busy      <= !((w_state_nxt == S_LOAD) && (w_cnt_nxt == '0));
            if (w_state_nxt == S_DRAIN) r_m_data <= w_zword;
            if (w_cap) r_zbuf <= bus.eng_Z;
            if (w_s_hs) begin
                for (int i = 0; i < NA; i++)
                    if (r_cnt == CW'(i)) r_eng_A[i*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
                for (int i = 0; i < NV; i++)
                    if (r_cnt == CW'(NA + i)) r_eng_V[i*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
                for (int i = 0; i < L; i++)
                    if (r_cnt == CW'(NA + NV + i)) r_eng_prec[i] <= bus.s_data[3:0];
            end
        end
    end

    assign bus.s_ready   = (r_state == S_LOAD);
    assign bus.eng_start = r_eng_start;
    assign bus.eng_A     = r_eng_A;
    assign bus.eng_V     = r_eng_V;
    assign bus.eng_prec  = r_eng_prec;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_data    = r_m_data;
    assign bus.m_last    = r_m_last;
    assign busy          = r_busy;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_attention_av_stream_bridge.sv
// Bench for attention_av_stream_bridge: stub engine, stream driver/sink, queue-based
// reference model compared every cycle, plus literal checks of the documented scenarios.
module tb_attention_av_stream_bridge;
    localparam int DW      = 16;
    localparam int L       = 8;
    localparam int N       = 1;
    localparam int E       = 8;
    localparam int TIMEOUT = 100;
    localparam int NA      = L * N * L;
    localparam int NV      = L * N * E;
    localparam int W       = NA + NV + L;
    localparam int WIDE    = (DW * NA > DW * NV) ? DW * NA : DW * NV;
    localparam int BOUND   = 5000;
`ifdef ATTN_BRIDGE_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, err;
    logic [1:0] dbg_state;

    attention_av_stream_bridge_if #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E)) bus ();

    attention_av_stream_bridge #(
        .DATA_WIDTH(DW), .L(L), .N(N), .E(E), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .busy        (busy),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // ---------------- model state ----------------
    int              ld_cnt    = 0;
    bit              job_open  = 1'b0;
    bit              wait_open = 1'b0;
    bit              exp_start = 1'b0;
    bit              err_exp   = 1'b0;
    int              wcnt      = 0;
    logic [DW-1:0]   acc [W];
    logic [DW*NA-1:0] exp_A;
    logic [DW*NV-1:0] exp_V;
    logic [L-1:0][3:0] exp_prec;
    logic [DW-1:0]   exp_q [$];
    logic [DW-1:0]   out_log [$];

    // stimulus controls
    int            stub_k     = 20;
    bit            stub_never = 1'b0;
    int            z_mult     = 3;
    int            z_off      = 0;
    int            ready_mode = 0;
    int            rdy_phase  = 0;
    logic [DW-1:0] job_w [W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_wide(input string name, input logic [WIDE-1:0] act,
                              input logic [WIDE-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            for (int i = 0; i < WIDE / DW; i++) begin
                if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
                    $display("FAIL %s slice %0d act=%0h exp=%0h t=%0t", name, i,
                             act[i*DW +: DW], exp[i*DW +: DW], $time);
                    break;
                end
            end
        end
    endtask

    // ---------------- reference model (updated on each edge) ----------------
    always @(posedge clk) begin
        bit hs, pop;
        cyc++;
        if (!rst_n) begin
            ld_cnt = 0; job_open = 0; wait_open = 0; exp_start = 0; err_exp = 0; wcnt = 0;
            exp_q.delete();
        end else begin
            hs  = bus.s_valid && !job_open;
            pop = (exp_q.size() > 0) && bus.m_ready;
            exp_start = 1'b0;
            if (pop) begin
                out_log.push_back(exp_q.pop_front());
                if (exp_q.size() == 0) job_open = 1'b0;
            end
            if (wait_open) begin
                wcnt++;
                if (bus.eng_done && wcnt >= 2) begin
                    for (int i = 0; i < NV; i++) exp_q.push_back(bus.eng_Z[i*DW +: DW]);
                    wait_open = 1'b0;
                end else if (WDOG && wcnt == TIMEOUT) begin
                    err_exp = 1'b1; job_open = 1'b0; wait_open = 1'b0;
                end
            end
            if (hs) begin
                acc[ld_cnt] = bus.s_data;
                if (ld_cnt == W - 1) begin
                    ld_cnt = 0; job_open = 1'b1; wait_open = 1'b1; wcnt = 0; exp_start = 1'b1;
                    for (int j = 0; j < NA; j++) exp_A[j*DW +: DW] = acc[j];
                    for (int j = 0; j < NV; j++) exp_V[j*DW +: DW] = acc[NA + j];
                    for (int j = 0; j < L; j++)  exp_prec[j] = acc[NA + NV + j][3:0];
                end else begin
                    ld_cnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("s_ready", bus.s_ready, !job_open);
            check("eng_start", bus.eng_start, exp_start);
            check("m_valid", bus.m_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("m_data", bus.m_data, exp_q[0]);
                check("m_last", bus.m_last, exp_q.size() == 1);
            end
            check("busy", busy, job_open || (ld_cnt != 0));
            check("err", err, err_exp);
            if (wait_open) begin
                check_wide("eng_A", bus.eng_A, exp_A);
                check_wide("eng_V", bus.eng_V, exp_V);
                check("eng_prec", bus.eng_prec, exp_prec);
            end
        end
    end

    // ---------------- stub engine ----------------
    initial begin
        bus.eng_done = 1'b0;
        bus.eng_Z    = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && bus.eng_start && !stub_never) begin
                repeat (stub_k) @(posedge clk);
                #1;
                for (int i = 0; i < NV; i++) bus.eng_Z[i*DW +: DW] = DW'(z_mult * i + z_off);
                bus.eng_done = 1'b1;
                @(posedge clk); #1;
                bus.eng_done = 1'b0;
            end
        end
    end

    // ---------------- output sink ----------------
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: begin
                    bus.m_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                    rdy_phase++;
                end
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic send_word(input logic [DW-1:0] d, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        t = 0;
        while (!bus.s_ready && t < BOUND) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= BOUND) begin
            n_checks++; n_err++;
            $display("FAIL s_ready_wait act=timeout exp=ready within %0d cycles", BOUND);
        end
        @(posedge clk); #1;
    endtask

    task automatic make_job(input bit rnd);
        for (int i = 0; i < W; i++) begin
            if (rnd)             job_w[i] = DW'($urandom_range(0, 65535));
            else if (i < NA)     job_w[i] = DW'(16'h0100 + i);
            else if (i < NA+NV)  job_w[i] = DW'(16'h0200 + (i - NA));
            else                 job_w[i] = DW'(i - NA - NV);
        end
    endtask

    task automatic load_job(input bit gaps, input bit hold);
        for (int i = 0; i < W; i++) send_word(job_w[i], gaps);
        if (!hold) bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (job_open && t < BOUND) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= BOUND) begin
            n_checks++; n_err++;
            $display("FAIL drain_wait act=timeout exp=job closed within %0d cycles", BOUND);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int start_cyc, t;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_eng_start", bus.eng_start, 0);
        check_wide("rst_eng_A", bus.eng_A, '0);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1;

        // Job 1: deterministic words, full-rate sink, Z = 3*i
        ready_mode = 0; z_mult = 3; z_off = 0; stub_k = 20;
        out_log.delete();
        make_job(1'b0);
        load_job(1'b0, 1'b0);
        check("t1_start_after_last", bus.eng_start, 1);
        check("t1_A5", bus.eng_A[5*DW +: DW], 16'h0105);
        check("t1_V63", bus.eng_V[63*DW +: DW], 16'h023F);
        check("t1_prec7", bus.eng_prec[7], 4'd7);
        @(posedge clk); #1;
        check("t1_start_one_cycle", bus.eng_start, 0);
        wait_idle();
        check("t2_count", out_log.size(), 64);
        if (out_log.size() == 64) begin
            check("t2_first", out_log[0], 0);
            check("t2_w1", out_log[1], 3);
            check("t2_last", out_log[63], 189);
        end
        check("t2_s_ready_after", bus.s_ready, 1);

        // Job 2: stalling sink 1,0,0,1
        ready_mode = 1; rdy_phase = 0; z_mult = 5; z_off = 7;
        out_log.delete();
        make_job(1'b1);
        load_job(1'b0, 1'b0);
        wait_idle();
        check("t3_count", out_log.size(), 64);
        if (out_log.size() == 64) check("t3_w10", out_log[10], 57);

        // Jobs 3+4: gaps on load, s_valid held high through wait/drain
        ready_mode = 2; z_mult = 11; z_off = 1;
        out_log.delete();
        make_job(1'b1);
        load_job(1'b1, 1'b1);
        make_job(1'b1);
        load_job(1'b1, 1'b0);
        wait_idle();
        check("t4_count", out_log.size(), 128);

        // Reset during S_WAIT, then stub done arrives and must be ignored
        ready_mode = 0;
        out_log.delete();
        make_job(1'b1);
        load_job(1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("t5_state", dbg_state, 0);
        check("t5_m_valid", bus.m_valid, 0);
        check("t5_eng_start", bus.eng_start, 0);
        check("t5_s_ready", bus.s_ready, 1);
        check("t5_no_words", out_log.size(), 0);
        @(posedge clk); #1;

        // Recovery job after reset
        make_job(1'b1);
        load_job(1'b0, 1'b0);
        wait_idle();
        check("t5_recover_count", out_log.size(), 64);

        // Engine never finishes
        stub_never = 1'b1;
        out_log.delete();
        make_job(1'b1);
        load_job(1'b0, 1'b0);
        start_cyc = cyc;
`ifdef ATTN_BRIDGE_WDOG_EN
        t = 0;
        while (!err && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("t6_err", err, 1);
        check("t6_err_delay", cyc - start_cyc, TIMEOUT);
        check("t6_s_ready", bus.s_ready, 1);
        check("t6_m_valid", bus.m_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_words", out_log.size(), 0);
`else
        t = 0;
        repeat (2000) @(posedge clk);
        #1;
        check("t6_err", err, 0);
        check("t6_state_wait", dbg_state, 2);
        check("t6_s_ready", bus.s_ready, 0);
        check("t6_busy", busy, 1);
        check("t6_elapsed", cyc - start_cyc, 2000 + t);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
